// File: rtl/lstm_fixed_pkg.sv
// Fixed-point definitions shared by the LSTM datapath: Q formats, 4-lane packing,
// dot-product sequencer states and the accumulator-to-lane saturating resize.
package lstm_fixed_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned ACC_WIDTH  = 20;
    localparam int unsigned Q_VEC_FRAC = 12;  // Q4.12 vectors and results
    localparam int unsigned Q_WGT_FRAC = 14;  // Q2.14 weights

    typedef logic signed [DATA_WIDTH-1:0] lane_t;
    typedef lane_t [3:0] lane4_t;  // lane 0 in the least significant bits

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDrain,
        StOut,
        StDone
    } dot_state_e;

    // Clamp a Q8.12 accumulator into the Q4.12 lane range.
    function automatic logic [DATA_WIDTH-1:0] sat_resize(input logic [ACC_WIDTH-1:0] acc);
        logic [ACC_WIDTH-DATA_WIDTH:0] upper;
        upper = acc[ACC_WIDTH-1:DATA_WIDTH-1];
        if (upper == '0 || upper == '1) begin
            return acc[DATA_WIDTH-1:0];
        end
        return acc[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    endfunction

endpackage

// File: rtl/dot_seq4.sv
// Dot-product sequencer driving an external 4-lane MAC; one Q4.12 result per row.
// Define DOT_SEQ_SAT_EN to saturate row results instead of wrapping them.
module dot_seq4
    import lstm_fixed_pkg::*;
#(
    parameter int unsigned GW = 8,
    parameter int unsigned RW = 8,
    parameter int unsigned AW = 12
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [GW-1:0]           i_num_groups,
    input  logic [RW-1:0]           i_num_rows,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_w_en,
    output logic [AW-1:0]           o_w_addr,
    input  logic [4*DATA_WIDTH-1:0] i_w_rdata,
    output logic                    o_x_en,
    output logic [GW-1:0]           o_x_addr,
    input  logic [4*DATA_WIDTH-1:0] i_x_rdata,
    output logic [DATA_WIDTH-1:0]   o_mac_a0,
    output logic [DATA_WIDTH-1:0]   o_mac_a1,
    output logic [DATA_WIDTH-1:0]   o_mac_a2,
    output logic [DATA_WIDTH-1:0]   o_mac_a3,
    output logic [DATA_WIDTH-1:0]   o_mac_b0,
    output logic [DATA_WIDTH-1:0]   o_mac_b1,
    output logic [DATA_WIDTH-1:0]   o_mac_b2,
    output logic [DATA_WIDTH-1:0]   o_mac_b3,
    input  logic [DATA_WIDTH-1:0]   i_mac_result,
    output logic [DATA_WIDTH-1:0]   o_y_data,
    output logic [RW-1:0]           o_y_row,
    output logic                    o_y_valid,
    input  logic                    i_y_ready
);

    dot_state_e           r_state;
    logic [GW-1:0]        r_num_groups;
    logic [RW-1:0]        r_num_rows;
    logic [GW-1:0]        r_g;
    logic [RW-1:0]        r_row;
    logic [AW-1:0]        r_wptr;
    logic                 r_req;
    logic                 r_acc_vld;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_busy;
    logic                 r_done;
    logic [DATA_WIDTH-1:0] r_y_data;
    logic [RW-1:0]        r_y_row;
    logic                 r_y_valid;

    lane4_t               w_wlanes;
    lane4_t               w_xlanes;
    logic [ACC_WIDTH-1:0] w_mac_ext;
    logic [ACC_WIDTH-1:0] w_acc_sum;
    logic [ACC_WIDTH-1:0] w_acc_next;
    logic [DATA_WIDTH-1:0] w_y_reduced;

    assign w_wlanes = i_w_rdata;
    assign w_xlanes = i_x_rdata;

    assign w_mac_ext  = {{(ACC_WIDTH-DATA_WIDTH){i_mac_result[DATA_WIDTH-1]}}, i_mac_result};
    assign w_acc_sum  = r_acc + w_mac_ext;
    assign w_acc_next = r_acc_vld ? w_acc_sum : r_acc;

`ifdef DOT_SEQ_SAT_EN
    assign w_y_reduced = sat_resize(w_acc_next);
`else
    assign w_y_reduced = w_acc_next[DATA_WIDTH-1:0];
`endif

    // Lanes are only shown to the MAC while the memory data belongs to a live request.
    always_comb begin
        o_mac_a0 = '0;
        o_mac_a1 = '0;
        o_mac_a2 = '0;
        o_mac_a3 = '0;
        o_mac_b0 = '0;
        o_mac_b1 = '0;
        o_mac_b2 = '0;
        o_mac_b3 = '0;
        if (r_acc_vld) begin
            o_mac_a0 = w_wlanes[0];
            o_mac_a1 = w_wlanes[1];
            o_mac_a2 = w_wlanes[2];
            o_mac_a3 = w_wlanes[3];
            o_mac_b0 = w_xlanes[0];
            o_mac_b1 = w_xlanes[1];
            o_mac_b2 = w_xlanes[2];
            o_mac_b3 = w_xlanes[3];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_num_groups <= '0;
            r_num_rows   <= '0;
            r_g          <= '0;
            r_row        <= '0;
            r_wptr       <= '0;
            r_req        <= 1'b0;
            r_acc_vld    <= 1'b0;
            r_acc        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_y_data     <= '0;
            r_y_row      <= '0;
            r_y_valid    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_acc_vld <= r_req;
            if (r_acc_vld) begin
                r_acc <= w_acc_sum;
            end

            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_num_groups <= i_num_groups;
                        r_num_rows   <= i_num_rows;
                        r_row        <= '0;
                        r_wptr       <= '0;
                        if (i_num_groups == '0 || i_num_rows == '0) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StFetch;
                            r_busy  <= 1'b1;
                            r_acc   <= '0;
                            r_g     <= '0;
                            r_req   <= 1'b1;
                        end
                    end
                end

                StFetch: begin
                    // wptr keeps running across rows so it lands on the next row's base.
                    r_wptr <= r_wptr + AW'(1);
                    if (r_g == r_num_groups - GW'(1)) begin
                        r_state <= StDrain;
                        r_req   <= 1'b0;
                    end else begin
                        r_g <= r_g + GW'(1);
                    end
                end

                StDrain: begin
                    r_state   <= StOut;
                    r_y_valid <= 1'b1;
                    r_y_data  <= w_y_reduced;
                    r_y_row   <= r_row;
                end

                StOut: begin
                    if (i_y_ready) begin
                        r_y_valid <= 1'b0;
                        if (r_row == r_num_rows - RW'(1)) begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_row   <= r_row + RW'(1);
                            r_state <= StFetch;
                            r_acc   <= '0;
                            r_g     <= '0;
                            r_req   <= 1'b1;
                        end
                    end
                end

                StDone: begin
                    r_state <= StIdle;
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_w_en    = r_req;
    assign o_x_en    = r_req;
    assign o_w_addr  = r_wptr;
    assign o_x_addr  = r_g;
    assign o_y_data  = r_y_data;
    assign o_y_row   = r_y_row;
    assign o_y_valid = r_y_valid;

endmodule

// File: tb/tb_dot_seq4.sv
// Scoreboard bench for dot_seq4 with behavioural memories, MAC and row reference model.
module tb_dot_seq4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_groups;
    logic [7:0]  num_rows;
    logic        busy, done;
    logic        w_en, x_en;
    logic [11:0] w_addr;
    logic [7:0]  x_addr;
    logic [63:0] w_rdata, x_rdata;
    logic [15:0] mac_a0, mac_a1, mac_a2, mac_a3;
    logic [15:0] mac_b0, mac_b1, mac_b2, mac_b3;
    logic [15:0] mac_result;
    logic [15:0] y_data;
    logic [7:0]  y_row;
    logic        y_valid;
    logic        y_ready;

    always #5 clk = ~clk;

    dot_seq4 dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_num_groups (num_groups),
        .i_num_rows   (num_rows),
        .o_busy       (busy),
        .o_done       (done),
        .o_w_en       (w_en),
        .o_w_addr     (w_addr),
        .i_w_rdata    (w_rdata),
        .o_x_en       (x_en),
        .o_x_addr     (x_addr),
        .i_x_rdata    (x_rdata),
        .o_mac_a0     (mac_a0),
        .o_mac_a1     (mac_a1),
        .o_mac_a2     (mac_a2),
        .o_mac_a3     (mac_a3),
        .o_mac_b0     (mac_b0),
        .o_mac_b1     (mac_b1),
        .o_mac_b2     (mac_b2),
        .o_mac_b3     (mac_b3),
        .i_mac_result (mac_result),
        .o_y_data     (y_data),
        .o_y_row      (y_row),
        .o_y_valid    (y_valid),
        .i_y_ready    (y_ready)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural MAC: four Q2.14 x Q4.12 products summed, returned as Q4.12.
    function automatic logic [15:0] mac4(input logic [63:0] a, input logic [63:0] b);
        longint s;
        s = 0;
        for (int i = 0; i < 4; i++)
            s += longint'($signed(a[16*i +: 16])) * longint'($signed(b[16*i +: 16]));
        return 16'(s >>> 14);
    endfunction

    assign mac_result = mac4({mac_a3, mac_a2, mac_a1, mac_a0}, {mac_b3, mac_b2, mac_b1, mac_b0});

    logic [63:0] wmem [0:4095];
    logic [63:0] xmem [0:255];
    logic        en_d = 1'b0;

    always @(posedge clk) begin
        if (w_en === 1'b1) w_rdata <= wmem[w_addr];
        if (x_en === 1'b1) x_rdata <= xmem[x_addr];
        en_d <= (w_en === 1'b1) && !rst;
    end

    // Row result from the memory contents: sum of MAC outputs, 20-bit wrap, then reduce.
    function automatic logic [15:0] ref_row(input int g, input int base);
        int acc, w;
        acc = 0;
        for (int k = 0; k < g; k++) acc += int'($signed(mac4(wmem[base+k], xmem[k])));
        w = (acc <<< 12) >>> 12;
`ifdef DOT_SEQ_SAT_EN
        if (w > 32767) return 16'h7FFF;
        if (w < -32768) return 16'h8000;
`endif
        return w[15:0];
    endfunction

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  row;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    // Stimulus-owned control
    bit expect_accept;
    int cur_g;
    int rdy_mode;
    int done_exp;

    // Monitor-owned state
    int          t_ref = 0;
    int          done_seen = 0;
    logic        prev_valid = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic [7:0]  prev_row = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
            prev_stall <= 1'b0;
        end else begin
            if (start && expect_accept) t_ref <= ncyc;
            if (en_d) begin
                chk("mac_a_lanes", {mac_a3, mac_a2, mac_a1, mac_a0}, w_rdata);
                chk("mac_b_lanes", {mac_b3, mac_b2, mac_b1, mac_b0}, x_rdata);
            end else begin
                chk("mac_a_idle", {mac_a3, mac_a2, mac_a1, mac_a0}, 64'd0);
                chk("mac_b_idle", {mac_b3, mac_b2, mac_b1, mac_b0}, 64'd0);
            end
            chk("en_pair", x_en, w_en);
            if (y_valid && !y_ready) chk("bp_no_req", {w_en, x_en}, 2'b00);
            if (prev_stall) begin
                chk("hold_valid", y_valid, 1'b1);
                chk("hold_data", y_data, prev_data);
                chk("hold_row", y_row, prev_row);
            end
            if (y_valid && !prev_valid) chk("valid_latency", ncyc - t_ref, cur_g + 2);
            if (y_valid && y_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL y_unexpected: got row %0d data %0h expected no output", y_row,
                             y_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("y_data", y_data, mon_e.data);
                    chk("y_row", y_row, mon_e.row);
                end
                t_ref <= ncyc;
            end
            if (done) begin
                chk("done_latency", ncyc - t_ref, 1);
                chk("done_busy", busy, 1'b0);
                done_seen <= done_seen + 1;
            end
            prev_valid <= y_valid;
            prev_stall <= y_valid && !y_ready;
            prev_data  <= y_data;
            prev_row   <= y_row;
        end
    end

    // Consumer: always ready, random, or a 5-cycle stall on row 1.
    int stall_left = 5;
    initial begin
        y_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: y_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (y_valid && y_row == 8'd1 && stall_left > 0) begin
                        y_ready = 1'b0;
                        stall_left--;
                    end else begin
                        y_ready = 1'b1;
                    end
                end
                default: y_ready = 1'b1;
            endcase
            if (rdy_mode != 2) stall_left = 5;
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_en"}, {w_en, x_en, y_valid}, 3'b000);
        chk({tag, "_addr"}, {w_addr, x_addr}, 20'd0);
        chk({tag, "_y"}, {y_data, y_row}, 24'd0);
        chk({tag, "_mac"}, {mac_a3, mac_a2, mac_a1, mac_a0, mac_b3, mac_b2, mac_b1, mac_b0} == '0,
            1'b1);
    endtask

    task automatic wait_done();
        int target;
        int i;
        target = done_seen + 1;
        i = 0;
        while (done_seen < target && i < 3000) begin
            @(posedge clk);
            i++;
        end
        if (done_seen < target) begin
            n_checks++;
            n_err++;
            $display("FAIL done_timeout: got %0d done pulses expected %0d", done_seen, target);
        end
    endtask

    task automatic run_job(input int g, input int r, input int kind, input int rmode,
                           input bit poke);
        exp_t e;
        logic [15:0] lane;
        for (int k = 0; k < g; k++) begin
            case (kind)
                1, 2:    xmem[k] = {4{16'h1000}};
                4:       xmem[k] = {4{16'h1C00}};
                default: xmem[k] = {$urandom, $urandom};
            endcase
        end
        for (int row = 0; row < r; row++) begin
            for (int k = 0; k < g; k++) begin
                lane = 16'(16'h1000 * (row + 1));
                case (kind)
                    1, 4:    wmem[row*g+k] = {4{16'h4000}};
                    2:       wmem[row*g+k] = {4{lane}};
                    default: wmem[row*g+k] = {$urandom, $urandom};
                endcase
            end
            e.data = ref_row(g, row * g);
            e.row  = 8'(row);
            sb_q.push_back(e);
        end
        cur_g = g;
        rdy_mode = rmode;
        done_exp++;
        @(posedge clk);
        #1;
        num_groups = 8'(g);
        num_rows = 8'(r);
        expect_accept = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (poke) begin
            @(posedge clk);
            #1;
            expect_accept = 1'b0;
            num_groups = 8'd5;
            num_rows = 8'd1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_done();
        rdy_mode = 0;
    endtask

    task automatic run_empty(input int g, input int r);
        cur_g = g;
        done_exp++;
        @(posedge clk);
        #1;
        num_groups = 8'(g);
        num_rows = 8'(r);
        expect_accept = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("empty_quiet", {w_en, x_en, y_valid, busy}, 4'b0000);
        end
    endtask

    task automatic reset_mid_job();
        for (int k = 0; k < 4; k++) begin
            wmem[k] = {$urandom, $urandom};
            xmem[k] = {$urandom, $urandom};
        end
        cur_g = 4;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        num_groups = 8'd4;
        num_rows = 8'd1;
        expect_accept = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("mid_rst");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_groups = '0;
        num_rows = '0;
        expect_accept = 1'b0;
        cur_g = 1;
        rdy_mode = 0;
        done_exp = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("reset");

        run_job(1, 1, 1, 0, 1'b0);
        run_job(2, 3, 2, 0, 1'b0);
        run_job(2, 3, 2, 2, 1'b0);
        run_job(2, 1, 4, 0, 1'b0);
        run_empty(3, 0);
        run_empty(0, 2);
        run_job(3, 2, 0, 0, 1'b1);
        reset_mid_job();
        run_job(2, 2, 0, 0, 1'b0);
        repeat (8) run_job(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)), 0, 1, 1'b0);

        repeat (4) @(posedge clk);
        chk("sb_drained", sb_q.size(), 0);
        chk("done_count", done_seen, done_exp);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
